// File: rtl/gpa_fhdo_spi_responder.sv
// rtl/gpa_fhdo_spi_responder.sv - SPI responder emulating the GPA-FHDO DAC/SYNC registers with optional ADC readback.
// Optional ADC readback on spi_sdo_o is built only when GPA_FHDO_RESP_ADC_EN is defined.
module gpa_fhdo_spi_responder #(
    parameter int ADC_IDLE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk_i,
    input  logic        spi_sdi_i,
    input  logic        spi_csn_i,
    output logic        spi_sdo_o,
    input  logic [15:0] adc_value_i,
    output logic [15:0] dac0_o,
    output logic [15:0] dac1_o,
    output logic [15:0] dac2_o,
    output logic [15:0] dac3_o,
    output logic [15:0] sync_reg_o,
    output logic [23:0] frame_data_o,
    output logic        frame_valid_o,
    output logic        frame_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [1:0]  sclk_sync;
    logic [1:0]  sdi_sync;
    logic [1:0]  csn_sync;
    logic        sclk_d;
    logic        csn_d;
    logic        sclk_s;
    logic        sdi_s;
    logic        csn_s;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        csn_rise;
    logic        csn_fall;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [23:0] shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            sdi_sync  <= 2'b00;
            csn_sync  <= 2'b00;
            sclk_d    <= 1'b0;
            csn_d     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk_i};
            sdi_sync  <= {sdi_sync[0], spi_sdi_i};
            csn_sync  <= {csn_sync[0], spi_csn_i};
            sclk_d    <= sclk_sync[1];
            csn_d     <= csn_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign sdi_s     = sdi_sync[1];
    assign csn_s     = csn_sync[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign csn_rise  = csn_s & ~csn_d;
    assign csn_fall  = ~csn_s & csn_d;

    // Clock-edge handling precedes the CSN rise check so a final SCLK fall coinciding with CSN rise is still counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= 5'd0;
            shift         <= 24'd0;
            frame_data_o  <= 24'd0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            dac0_o        <= 16'd0;
            dac1_o        <= 16'd0;
            dac2_o        <= 16'd0;
            dac3_o        <= 16'd0;
            sync_reg_o    <= 16'hFF00;
        end else begin
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        state   <= RX;
                        bit_cnt <= 5'd0;
                        shift   <= 24'd0;
                    end
                end
                RX: begin
                    if (sclk_fall) begin
                        shift <= {shift[22:0], sdi_s};
                        if (bit_cnt != 5'd31) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    if (csn_rise) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (bit_cnt == 5'd24) begin
                        frame_data_o  <= shift;
                        frame_valid_o <= 1'b1;
                        if (!shift[23]) begin
                            case (shift[19:16])
                                4'h2: sync_reg_o <= shift[15:0];
                                4'h6: begin
                                    dac0_o <= shift[15:0];
                                    dac1_o <= shift[15:0];
                                    dac2_o <= shift[15:0];
                                    dac3_o <= shift[15:0];
                                end
                                4'h8: dac0_o <= shift[15:0];
                                4'h9: dac1_o <= shift[15:0];
                                4'hA: dac2_o <= shift[15:0];
                                4'hB: dac3_o <= shift[15:0];
                                default: ;
                            endcase
                        end
                    end else begin
                        frame_err_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GPA_FHDO_RESP_ADC_EN
    localparam int IDLE_W = $clog2(ADC_IDLE_CYCLES + 1);

    logic [5:0]        adc_cnt;
    logic [15:0]       adc_hold;
    logic [IDLE_W-1:0] idle_cnt;
    logic              sdo_q;

    // adc_cnt holds the number of SCLK rises seen; it saturates at 32 so later edges keep SDO low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_cnt  <= 6'd0;
            adc_hold <= 16'd0;
            idle_cnt <= '0;
            sdo_q    <= 1'b0;
        end else if (csn_fall || !csn_s) begin
            adc_cnt  <= 6'd0;
            idle_cnt <= '0;
            sdo_q    <= 1'b0;
        end else if (sclk_rise) begin
            idle_cnt <= '0;
            if (adc_cnt == 6'd0) begin
                adc_hold <= adc_value_i;
            end
            if (adc_cnt != 6'd32) begin
                adc_cnt <= adc_cnt + 6'd1;
            end
            if (adc_cnt >= 6'd31) begin
                sdo_q <= 1'b0;
            end
        end else if (sclk_fall) begin
            idle_cnt <= '0;
            if (adc_cnt[5:4] == 2'b01) begin
                sdo_q <= adc_hold[~adc_cnt[3:0]];
            end else begin
                sdo_q <= 1'b0;
            end
        end else if (idle_cnt == IDLE_W'(ADC_IDLE_CYCLES - 1)) begin
            adc_cnt <= 6'd0;
            sdo_q   <= 1'b0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign spi_sdo_o = sdo_q;
`else
    logic unused_adc;

    assign unused_adc = ^{adc_value_i, sclk_rise, ADC_IDLE_CYCLES[0]};
    assign spi_sdo_o  = 1'b0;
`endif

endmodule
